// File: rtl/mips_disp_pkg.sv
// Shared constants and the seven-segment decoder for the mips debug display.
package mips_disp_pkg;

  localparam logic [2:0] PAGE_PC     = 3'd0;
  localparam logic [2:0] PAGE_PCNEXT = 3'd1;
  localparam logic [2:0] PAGE_INSTR  = 3'd2;
  localparam logic [2:0] PAGE_REG    = 3'd3;
  localparam logic [2:0] PAGE_MEM    = 3'd4;
  localparam logic [2:0] PAGE_STAT   = 3'd5;
  localparam int unsigned NUM_PAGES  = 6;

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mips_disp_scan_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, and a
// one-cycle pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic ResetN,
  input  logic BtnRaw,
  output logic Press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] count;

  // Level is accepted only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      count <= '0;
      Press <= 1'b0;
    end else begin
      sync1 <= BtnRaw;
      sync2 <= sync1;
      Press <= 1'b0;
      if (sync2 != level) begin
        if (count == CW'(DEB_CYCLES - 1)) begin
          level <= sync2;
          count <= '0;
          Press <= sync2;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/mips_disp_scan.sv
// Debug display stage: page/address stepping from two buttons and an
// 8-digit multiplexed seven-segment scan of a per-scan snapshot word.
module mips_disp_scan
  import mips_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEB_CYCLES  = 1000000
) (
  input  logic        CLK,
  input  logic        ResetN,
  input  logic [31:0] PC,
  input  logic [31:0] PCNext,
  input  logic [31:0] Instr,
  input  logic [31:0] DispReg,
  input  logic [31:0] DispMem,
  input  logic [3:0]  Stat,
  input  logic        BtnPage,
  input  logic        BtnAddr,
  output logic [6:0]  Disp,
  output logic [2:0]  Page,
  output logic [7:0]  An,
  output logic [7:0]  Seg
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);

  logic          press_page;
  logic          press_addr;
  logic [RW-1:0] refresh_cnt;
  logic [2:0]    digit;
  logic [31:0]   snapshot;
  logic          first_tick;

  logic          tick_c;
  logic [2:0]    next_digit_c;
  logic          load_c;
  logic [31:0]   page_word_c;
  logic [31:0]   scan_word_c;
  logic [3:0]    nibble_c;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_page (
    .CLK    (CLK),
    .ResetN (ResetN),
    .BtnRaw (BtnPage),
    .Press  (press_page)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_addr (
    .CLK    (CLK),
    .ResetN (ResetN),
    .BtnRaw (BtnAddr),
    .Press  (press_addr)
  );

  // Page-selected word and the nibble shown on the upcoming digit
  always_comb begin
    page_word_c = PC;
    case (Page)
      PAGE_PCNEXT: page_word_c = PCNext;
      PAGE_INSTR:  page_word_c = Instr;
      PAGE_REG:    page_word_c = DispReg;
      PAGE_MEM:    page_word_c = DispMem;
      PAGE_STAT:   page_word_c = {28'd0, Stat};
      default:     page_word_c = PC;
    endcase
    tick_c       = (refresh_cnt == RW'(REFRESH_DIV - 1));
    next_digit_c = digit + 3'd1;
    load_c       = (next_digit_c == 3'd0) || first_tick;
    scan_word_c  = load_c ? page_word_c : snapshot;
    nibble_c     = scan_word_c[{next_digit_c, 2'b00} +: 4];
  end

  // Page and view-address stepping; both buttons act independently
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      Page <= PAGE_PC;
      Disp <= 7'd0;
    end else begin
      if (press_page) begin
        Page <= (Page == 3'(NUM_PAGES - 1)) ? PAGE_PC : Page + 3'd1;
      end
      if (press_addr) begin
        Disp <= Disp + 7'd1;
      end
    end
  end

  // Digit scan; the snapshot only reloads when a new scan begins
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      refresh_cnt <= '0;
      digit       <= 3'd0;
      snapshot    <= 32'd0;
      first_tick  <= 1'b1;
      An          <= 8'hFE;
      Seg         <= 8'h40;
    end else if (tick_c) begin
      refresh_cnt <= '0;
      digit       <= next_digit_c;
      first_tick  <= 1'b0;
      if (load_c) begin
        snapshot <= page_word_c;
      end
      An  <= ~(8'd1 << next_digit_c);
      Seg <= {~(next_digit_c == Page), hex_to_seg(nibble_c)};
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_disp_scan.sv
// Directed bench for mips_disp_scan with a short refresh and debounce period.
module tb_mips_disp_scan;

  logic        CLK = 1'b0;
  logic        ResetN;
  logic [31:0] PC, PCNext, Instr, DispReg, DispMem;
  logic [3:0]  Stat;
  logic        BtnPage, BtnAddr;
  logic [6:0]  Disp;
  logic [2:0]  Page;
  logic [7:0]  An, Seg;

  int checks = 0;
  int errors = 0;
  logic [6:0] hex_tbl [16];

  mips_disp_scan #(.REFRESH_DIV(4), .DEB_CYCLES(8)) dut (
    .CLK(CLK), .ResetN(ResetN), .PC(PC), .PCNext(PCNext), .Instr(Instr),
    .DispReg(DispReg), .DispMem(DispMem), .Stat(Stat),
    .BtnPage(BtnPage), .BtnAddr(BtnAddr),
    .Disp(Disp), .Page(Page), .An(An), .Seg(Seg)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input string tag, input logic [7:0] want, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (An === want) break;
    end
    chk(tag, {24'd0, An}, {24'd0, want});
  endtask

  task automatic press(input logic pg, input logic ad);
    BtnPage = pg;
    BtnAddr = ad;
    repeat (14) tick();
    BtnPage = 1'b0;
    BtnAddr = 1'b0;
    repeat (14) tick();
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    repeat (2) tick();
    ResetN = 1'b1;
  endtask

  function automatic logic [7:0] seg_exp(input logic [31:0] w, input int d, input logic [2:0] pg);
    logic [3:0] n;
    n = w[4*d +: 4];
    return {(d == int'(pg)) ? 1'b0 : 1'b1, hex_tbl[n]};
  endfunction

  initial begin
    logic [2:0] old_p;
    logic [6:0] old_d;
    hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    ResetN = 1'b1;
    PC = 32'h0040_3004; PCNext = 32'h89AB_CDEF; Instr = 32'h1234_5678;
    DispReg = 32'hDEAD_BEEF; DispMem = 32'hCAFE_F00D; Stat = 4'h9;
    BtnPage = 1'b0; BtnAddr = 1'b0;

    // 1: asynchronous reset between clock edges
    repeat (2) tick();
    #3 ResetN = 1'b0;
    #1;
    chk("rst_an", {24'd0, An}, 32'hFE);
    chk("rst_seg", {24'd0, Seg}, 32'h40);
    chk("rst_page", {29'd0, Page}, 32'd0);
    chk("rst_disp", {25'd0, Disp}, 32'd0);
    tick(); tick();
    ResetN = 1'b1;

    // 2: scan of PC on page 0
    wait_an("t2_d1_first", 8'hFD, 10);
    wait_an("t2_d0", 8'hFE, 40);
    chk("t2_d0_seg", {24'd0, Seg}, 32'h19);
    repeat (3) tick();
    chk("t2_d0_hold", {24'd0, An}, 32'hFE);
    tick();
    chk("t2_d1_an", {24'd0, An}, 32'hFD);
    chk("t2_d1_seg", {24'd0, Seg}, 32'hC0);
    wait_an("t2_d3", 8'hF7, 20);
    chk("t2_d3_seg", {24'd0, Seg}, 32'hB0);
    wait_an("t2_d5", 8'hDF, 20);
    chk("t2_d5_seg", {24'd0, Seg}, 32'h99);
    wait_an("t2_d7", 8'h7F, 20);
    wait_an("t2_wrap", 8'hFE, 8);
    chk("t2_wrap_seg", {24'd0, Seg}, 32'h19);

    // 3: short press ignored, long press once, bouncy release ignored
    BtnPage = 1'b1; repeat (5) tick();
    BtnPage = 1'b0; repeat (14) tick();
    chk("t3_short", {29'd0, Page}, 32'd0);
    BtnPage = 1'b1; repeat (20) tick();
    chk("t3_long", {29'd0, Page}, 32'd1);
    for (int b = 0; b < 3; b++) begin
      BtnPage = 1'b0; repeat (3) tick();
      BtnPage = 1'b1; repeat (3) tick();
    end
    BtnPage = 1'b0; repeat (14) tick();
    chk("t3_bounce", {29'd0, Page}, 32'd1);

    // 4: six presses cycle the pages, then a mid-scan page change
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      press(1'b1, 1'b0);
      chk($sformatf("t4_page%0d", k), {29'd0, Page}, k % 6);
    end
    wait_an("t4_d0", 8'hFE, 40);
    BtnPage = 1'b1;
    wait_an("t4_d5", 8'hDF, 24);
    chk("t4_pg_mid", {29'd0, Page}, 32'd1);
    chk("t4_d5_old", {24'd0, Seg}, {24'd0, seg_exp(PC, 5, 3'd1)});
    BtnPage = 1'b0;
    wait_an("t4_d0_new", 8'hFE, 20);
    chk("t4_d0_seg", {24'd0, Seg}, {24'd0, seg_exp(PCNext, 0, 3'd1)});
    tick(); tick(); tick(); tick();
    chk("t4_d1_seg", {24'd0, Seg}, 32'h06);
    repeat (10) tick();

    // 5: address wrap and simultaneous presses
    for (int k = 0; k < 126; k++) press(1'b0, 1'b1);
    chk("t5_disp126", {25'd0, Disp}, 32'd126);
    press(1'b0, 1'b1);
    chk("t5_disp127", {25'd0, Disp}, 32'd127);
    press(1'b0, 1'b1);
    chk("t5_disp0", {25'd0, Disp}, 32'd0);
    old_p = Page;
    old_d = Disp;
    BtnPage = 1'b1; BtnAddr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Page !== old_p || Disp !== old_d) break;
    end
    chk("t5_both_page", {29'd0, Page}, 32'd2);
    chk("t5_both_disp", {25'd0, Disp}, 32'd1);
    BtnPage = 1'b0; BtnAddr = 1'b0;
    repeat (14) tick();

    // 6: reset during digit 5 with a half-counted press
    wait_an("t6_d3", 8'hF7, 40);
    BtnAddr = 1'b1;
    repeat (8) tick();
    chk("t6_d5", {24'd0, An}, 32'hDF);
    ResetN = 1'b0;
    #1;
    chk("t6_rst_an", {24'd0, An}, 32'hFE);
    chk("t6_rst_seg", {24'd0, Seg}, 32'h40);
    chk("t6_rst_page", {29'd0, Page}, 32'd0);
    chk("t6_rst_disp", {25'd0, Disp}, 32'd0);
    tick(); tick();
    ResetN = 1'b1;
    repeat (10) tick();
    chk("t6_not_yet", {25'd0, Disp}, 32'd0);
    tick();
    chk("t6_press", {25'd0, Disp}, 32'd1);
    BtnAddr = 1'b0;
    repeat (14) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
